yarvi_lsu: RTL

Parametrised load-store unit for the yarvi pipeline. It replaces the fixed-size memory stage. Memory size, address map and timer rate are set by parameters. Loads to the word written by the immediately preceding store are resolved by byte-accurate store-to-load forwarding rather than replay. It sits after execute, accepts one operation per cycle, and feeds writeback, the code-memory write port and the timer interrupt line.

---
 rtl/yarvi_pkg.sv | 40 ++++
 rtl/yarvi_mtimer.sv | 68 ++++++
 rtl/yarvi_lsu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/yarvi_pkg.sv
// yarvi_pkg: encodings and defaults shared by the yarvi memory stage.
package yarvi_pkg;

  // funct3 load/store size and sign encodings
  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  // funct3[1:0] access size
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // timer register word offsets inside the MMIO window
  localparam logic [1:0] MMIO_MTIME_LO    = 2'd0;
  localparam logic [1:0] MMIO_MTIME_HI    = 2'd1;
  localparam logic [1:0] MMIO_MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MMIO_MTIMECMP_HI = 2'd3;

  localparam logic [31:0] MEM_BASE_DEFAULT  = 32'h8000_0000;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

  // sign- or zero-extend an already right-aligned load value
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {{24{raw[7]}}, raw[7:0]};
      F3_H:    r = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   r = {24'd0, raw[7:0]};
      F3_HU:   r = {16'd0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/yarvi_mtimer.sv
// yarvi_mtimer: prescaled 64-bit mtime, mtimecmp, MMIO read mux and
// registered timer interrupt.
module yarvi_mtimer
  import yarvi_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_off,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_r, presc_nx_s;
  logic [63:0]   mtime_r, mtimecmp_r, mtime_inc_s, mtime_nx_s, cmp_nx_s;
  logic          tick_s;

  // next timer state: a written mtime half replaces its increment, the other
  // half keeps the carry computed from the old value
  always_comb begin
    tick_s      = (presc_r == PRESC_MAX);
    presc_nx_s  = tick_s ? {PW{1'b0}} : presc_r + 1'b1;
    mtime_inc_s = mtime_r + {63'd0, tick_s};
    mtime_nx_s  = mtime_inc_s;
    cmp_nx_s    = mtimecmp_r;
    if (wr_en) begin
      case (wr_off)
        MMIO_MTIME_LO:    mtime_nx_s[31:0]  = wr_data;
        MMIO_MTIME_HI:    mtime_nx_s[63:32] = wr_data;
        MMIO_MTIMECMP_LO: cmp_nx_s[31:0]    = wr_data;
        MMIO_MTIMECMP_HI: cmp_nx_s[63:32]   = wr_data;
        default:          cmp_nx_s          = mtimecmp_r;
      endcase
    end else begin
      mtime_nx_s = mtime_inc_s;
    end
    case (rd_off)
      MMIO_MTIME_LO:    rd_data = mtime_r[31:0];
      MMIO_MTIME_HI:    rd_data = mtime_r[63:32];
      MMIO_MTIMECMP_LO: rd_data = mtimecmp_r[31:0];
      MMIO_MTIMECMP_HI: rd_data = mtimecmp_r[63:32];
      default:          rd_data = 32'd0;
    endcase
  end

  // timer registers; mtimecmp resets to all ones so no interrupt fires at boot
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_r    <= {PW{1'b0}};
      mtime_r    <= 64'd0;
      mtimecmp_r <= {64{1'b1}};
      irq        <= 1'b0;
    end else begin
      presc_r    <= presc_nx_s;
      mtime_r    <= mtime_nx_s;
      mtimecmp_r <= cmp_nx_s;
      irq        <= (mtime_r >= mtimecmp_r);
    end
  end

endmodule

// File: rtl/yarvi_lsu.sv
// yarvi_lsu: memory stage with a parametrised data array, timer MMIO and
// one-cycle byte-accurate store-to-load forwarding.
module yarvi_lsu
  import yarvi_pkg::*;
#(
  parameter int          MEM_AW    = 16,
  parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int          FWD       = 1,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic        readenable,
  input  logic        writeenable,
  input  logic [31:0] pc,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  input  logic [2:0]  funct3,
  input  logic [31:0] writedata,
  output logic        me_valid,
  output logic [31:0] me_pc,
  output logic [4:0]  me_wb_rd,
  output logic [31:0] me_wb_val,
  output logic        me_exc_misaligned,
  output logic [31:0] me_exc_mtval,
  output logic        me_replay,
  output logic        me_timer_interrupt,
  output logic [31:0] code_address,
  output logic [31:0] code_writedata,
  output logic [3:0]  code_writemask
);

  localparam int WAW   = MEM_AW - 2;
  localparam int WORDS = 1 << WAW;
  localparam bit USE_FWD = (FWD != 32'sd0);

  // the code port registers double as the write buffer: the array is written
  // one cycle after the store, so the next load must merge them in
  logic [7:0]  lane_mem [4][WORDS];
  logic [31:0] rdata_r, fwd_data_r, mmio_rd_r, byp_r, mmio_rdata_s;
  logic [3:0]  fwd_mask_r, mask_s;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        ld_r, ld_mem_r, ld_mmio_r;
  logic [31:0] wdata_s, merged_s, word_s, shifted_s;
  logic        squash_s, live_s, in_mem_s, is_mmio_s, misal_s, exc_s, load_s;
  logic        store_s, mem_we_s, mmio_we_s, fwd_hit_s, replay_s, ok_s;

  // decode the incoming operation
  always_comb begin
    squash_s  = me_exc_misaligned | me_replay;
    live_s    = valid & ~squash_s;
    in_mem_s  = (wb_val[31:MEM_AW] == MEM_BASE[31:MEM_AW]);
    is_mmio_s = (wb_val[31:4] == MMIO_BASE[31:4]);
    case (funct3[1:0])
      SIZE_B: begin
        mask_s  = 4'b0001 << wb_val[1:0];
        wdata_s = {4{writedata[7:0]}};
        misal_s = 1'b0;
      end
      SIZE_H: begin
        mask_s  = wb_val[1] ? 4'hC : 4'h3;
        wdata_s = {2{writedata[15:0]}};
        misal_s = wb_val[0];
      end
      SIZE_W: begin
        mask_s  = 4'hF;
        wdata_s = writedata;
        misal_s = (wb_val[1:0] != 2'd0);
      end
      default: begin
        mask_s  = 4'h0;
        wdata_s = writedata;
        misal_s = 1'b0;
      end
    endcase
    exc_s     = live_s & (readenable | writeenable) & misal_s;
    load_s    = live_s & readenable & ~misal_s;
    store_s   = live_s & writeenable & ~misal_s;
    mem_we_s  = store_s & in_mem_s;
    mmio_we_s = store_s & is_mmio_s & (funct3[1:0] == SIZE_W);
    fwd_hit_s = load_s & in_mem_s & (code_writemask != 4'h0) &
                (code_address[MEM_AW-1:2] == wb_val[MEM_AW-1:2]);
    replay_s  = ~USE_FWD & fwd_hit_s;
    ok_s      = live_s & ~exc_s & ~replay_s;
  end

  // control state of the writeback stage
  always_ff @(posedge clock) begin
    if (reset) begin
      me_valid          <= 1'b0;
      me_wb_rd          <= 5'd0;
      me_exc_misaligned <= 1'b0;
      me_replay         <= 1'b0;
      code_writemask    <= 4'h0;
      ld_r              <= 1'b0;
      fwd_mask_r        <= 4'h0;
    end else begin
      me_valid          <= ok_s;
      me_wb_rd          <= ok_s ? wb_rd : 5'd0;
      me_exc_misaligned <= exc_s;
      me_replay         <= replay_s;
      code_writemask    <= mem_we_s ? mask_s : 4'h0;
      ld_r              <= load_s & ~replay_s;
      fwd_mask_r        <= fwd_hit_s ? code_writemask : 4'h0;
    end
  end

  // data payload of the writeback stage and code port
  always_ff @(posedge clock) begin
    me_pc          <= pc;
    me_exc_mtval   <= wb_val;
    code_address   <= wb_val;
    code_writedata <= wdata_s;
    byp_r          <= wb_val;
    f3_r           <= funct3;
    off_r          <= wb_val[1:0];
    ld_mem_r       <= in_mem_s;
    ld_mmio_r      <= is_mmio_s;
    fwd_data_r     <= code_writedata;
    mmio_rd_r      <= mmio_rdata_s;
  end

  // byte-lane array: buffered write, synchronous read returning old data
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (code_writemask[k]) begin
        lane_mem[k][code_address[MEM_AW-1:2]] <= code_writedata[8*k +: 8];
      end
      rdata_r[8*k +: 8] <= lane_mem[k][wb_val[MEM_AW-1:2]];
    end
  end

  // merge forwarded bytes, select source, align and extend
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      merged_s[8*k +: 8] = fwd_mask_r[k] ? fwd_data_r[8*k +: 8] : rdata_r[8*k +: 8];
    end
    if (ld_mmio_r) begin
      word_s = mmio_rd_r;
    end else if (ld_mem_r) begin
      word_s = merged_s;
    end else begin
      word_s = 32'd0;
    end
    shifted_s = word_s >> {off_r, 3'b000};
    me_wb_val = ld_r ? load_extend(shifted_s, f3_r) : byp_r;
  end

  yarvi_mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (mmio_we_s),
    .wr_off  (wb_val[3:2]),
    .wr_data (writedata),
    .rd_off  (wb_val[3:2]),
    .rd_data (mmio_rdata_s),
    .irq     (me_timer_interrupt)
  );

endmodule
